// File: rtl/dec3_8_pipe_if.sv
// ---------------------------------------------------------------------------
// dec3_8_pipe_if
// Purpose : Groups the two valid/ready streams of the pipelined 3-to-8
//           decoder. The input stream carries binary codes. The output stream
//           carries the one-hot select word.
// Signals : in_valid  - producer has a code on in_code
//           in_code   - 3-bit binary code 0..7
//           in_ready  - decoder accepts in_code this cycle
//           out_valid - decoder presents a decoded word on out_y
//           out_y     - one-hot decode of the FIFO head
//           out_ready - consumer accepts out_y this cycle
// Modports: master - producer/consumer side (drives in_*, out_ready)
//           slave  - decoder side (drives in_ready, out_valid, out_y)
// ---------------------------------------------------------------------------
interface dec3_8_pipe_if;
    logic       in_valid;
    logic [2:0] in_code;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_y;
    logic       out_ready;

    modport master (
        output in_valid, in_code, out_ready,
        input  in_ready, out_valid, out_y
    );

    modport slave (
        input  in_valid, in_code, out_ready,
        output in_ready, out_valid, out_y
    );
endinterface

// File: rtl/dec3_8_pipe.sv
// ---------------------------------------------------------------------------
// dec3_8_pipe
// Purpose : Registered 3-to-8 decoder at the decode end of the 8:3 encoder
//           path. Codes are buffered in a 2-entry FIFO. The head is presented
//           as a one-hot word. Completed output handshakes are counted.
// Params  : OUT_ACTIVE_LOW - 1: asserted bit is 0 and the others are 1
//                            0: asserted bit is 1 and the others are 0
//           CNT_W          - width of dec_count
// Ports   : clk       - single clock, rising edge
//           rst       - asynchronous, active-high reset
//           en        - 1: accept new codes; 0: in_ready held low while
//                       the FIFO keeps draining
//           bus       - valid/ready streams (slave modport)
//           dec_count - completed output handshakes, modulo 2**CNT_W
// ---------------------------------------------------------------------------
module dec3_8_pipe #(
    parameter bit OUT_ACTIVE_LOW = 1'b0,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    dec3_8_pipe_if.slave     bus,
    output logic [CNT_W-1:0] dec_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [7:0] INACTIVE = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;

    state_t     state_q, state_d;
    logic [2:0] head_q, head_d;
    logic [2:0] tail_q, tail_d;
    logic       push, pop;
    logic [7:0] onehot;

    // in_ready depends only on registered state, en and rst.
    // out_ready does not reach it combinationally.
    assign bus.in_ready  = en & ~rst & (state_q != FULL);
    assign bus.out_valid = (state_q != EMPTY);

    assign push = bus.in_valid  & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    // Occupancy FSM and FIFO data movement
    always_comb begin
        // NOTE: every output gets a default first, so a path that leaves
        // one unassigned cannot infer a latch.
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (push) begin
                    state_d = ONE;
                    head_d  = bus.in_code;
                end
            end
            ONE: begin
                if (push && !pop) begin
                    state_d = FULL;
                    tail_d  = bus.in_code;
                end else if (pop && !push) begin
                    state_d = EMPTY;
                end else if (push && pop) begin
                    // The head leaves and the new code replaces it.
                    head_d = bus.in_code;
                end
            end
            FULL: begin
                if (pop) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge.
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: FIFO storage has no reset. Nothing reads it unless the
    // occupancy state says it holds data, and the state is reset.
    always_ff @(posedge clk) begin
        head_q <= head_d;
        tail_q <= tail_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_count <= '0;
        end else if (pop) begin
            dec_count <= dec_count + CNT_W'(1);
        end
    end

    // Decode the head. Force all bits inactive when nothing is presented.
    assign onehot    = 8'b0000_0001 << head_q;
    assign bus.out_y = !bus.out_valid ? INACTIVE
                     : (OUT_ACTIVE_LOW ? ~onehot : onehot);

endmodule

// File: tb/tb_dec3_8_pipe.sv
// ---------------------------------------------------------------------------
// tb_dec3_8_pipe
// Two decoder instances:
//   u_dut - defaults (active-high output, 8-bit counter)
//   u_alt - OUT_ACTIVE_LOW=1, CNT_W=2
// The stimulus tasks push the hand-computed expected word into a queue when
// an input handshake happens. Each instance has a monitor that pops and
// compares on every output handshake, on the falling edge.
// ---------------------------------------------------------------------------
module tb_dec3_8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       en0, en1;
    logic [7:0] cnt_dut0;
    logic [1:0] cnt_dut1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    int cnt0 = 0;
    int cnt1 = 0;

    dec3_8_pipe_if bus0 ();
    dec3_8_pipe_if bus1 ();

    dec3_8_pipe u_dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en0),
        .bus       (bus0),
        .dec_count (cnt_dut0)
    );

    dec3_8_pipe #(.OUT_ACTIVE_LOW(1'b1), .CNT_W(2)) u_alt (
        .clk       (clk),
        .rst       (rst),
        .en        (en1),
        .bus       (bus1),
        .dec_count (cnt_dut1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present a code on instance sel and wait for it to be accepted.
    // Record the expected word when the input handshake happens.
    task automatic push(input bit sel, input logic [2:0] code, input logic [7:0] exp_y);
        logic rdy;
        bit   done;
        done = 1'b0;
        if (sel) begin bus1.in_valid = 1'b1; bus1.in_code = code; end
        else     begin bus0.in_valid = 1'b1; bus0.in_code = code; end
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            rdy = sel ? bus1.in_ready : bus0.in_ready;
            @(posedge clk);
            if (rdy) begin
                if (sel) q1.push_back(exp_y);
                else     q0.push_back(exp_y);
                done = 1'b1;
            end
            #1;
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL push_timeout: code %0d on bus%0d never accepted", code, sel);
        end
        if (sel) bus1.in_valid = 1'b0;
        else     bus0.in_valid = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor for u_dut (active-high, 8-bit counter)
    always @(negedge clk) begin
        if (!rst) begin
            check("m0_count", {24'b0, cnt_dut0}, cnt0 & 32'hFF);
            check("m0_valid", {31'b0, bus0.out_valid}, {31'b0, q0.size() != 0});
            if (bus0.out_valid && bus0.out_ready && q0.size() != 0) begin
                check("m0_y", {24'b0, bus0.out_y}, {24'b0, q0.pop_front()});
                cnt0++;
            end else if (!bus0.out_valid) begin
                check("m0_idle_y", {24'b0, bus0.out_y}, 32'h00);
            end
        end
    end

    // Monitor for u_alt (active-low, 2-bit counter)
    always @(negedge clk) begin
        if (!rst) begin
            check("m1_count", {30'b0, cnt_dut1}, cnt1 & 32'h3);
            check("m1_valid", {31'b0, bus1.out_valid}, {31'b0, q1.size() != 0});
            if (bus1.out_valid && bus1.out_ready && q1.size() != 0) begin
                check("m1_y", {24'b0, bus1.out_y}, {24'b0, q1.pop_front()});
                cnt1++;
            end else if (!bus1.out_valid) begin
                check("m1_idle_y", {24'b0, bus1.out_y}, 32'hFF);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] seq_y [8];
        logic [7:0] alt_y [5];
        logic [1:0] alt_cnt [5];
        seq_y   = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        alt_y   = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF};
        alt_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        rst = 1'b1;
        en0 = 1'b1;
        en1 = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_code = 3'd0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.in_code = 3'd0; bus1.out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_valid",     {31'b0, bus0.out_valid}, 32'd0);
        check("rst_y",         {24'b0, bus0.out_y},     32'h00);
        check("rst_in_ready",  {31'b0, bus0.in_ready},  32'd0);
        check("rst_count",     {24'b0, cnt_dut0},       32'd0);
        check("rst_alt_y",     {24'b0, bus1.out_y},     32'hFF);
        cycle();
        rst = 1'b0;

        // Codes 0..7 back-to-back with out_ready=1
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b0, 3'(i), seq_y[i]);
        repeat (3) @(negedge clk);
        check("seq_count", {24'b0, cnt_dut0}, 32'd8);

        // Asynchronous reset with two entries buffered
        cycle();
        bus0.out_ready = 1'b0;
        push(1'b0, 3'd1, 8'h02);
        push(1'b0, 3'd4, 8'h10);
        @(posedge clk);
        #3;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        cnt0 = 0;
        cnt1 = 0;
        #1;
        check("arst_valid", {31'b0, bus0.out_valid}, 32'd0);
        check("arst_y",     {24'b0, bus0.out_y},     32'h00);
        check("arst_count", {24'b0, cnt_dut0},       32'd0);
        cycle();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'b0, bus0.in_ready}, 32'd1);

        // Back-pressure: fill the FIFO and hold, then drain in order
        cycle();
        push(1'b0, 3'd5, 8'h20);
        push(1'b0, 3'd2, 8'h04);
        @(negedge clk);
        check("full_in_ready", {31'b0, bus0.in_ready}, 32'd0);
        repeat (3) @(negedge clk);
        check("hold_y",     {24'b0, bus0.out_y},     32'h20);
        check("hold_valid", {31'b0, bus0.out_valid}, 32'd1);
        cycle();
        bus0.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("drained_valid", {31'b0, bus0.out_valid}, 32'd0);

        // en=0 blocks new codes while the buffered one drains
        cycle();
        bus0.out_ready = 1'b0;
        push(1'b0, 3'd3, 8'h08);
        en0 = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.in_code  = 3'd7;
        repeat (2) @(negedge clk);
        check("en_off_in_ready", {31'b0, bus0.in_ready}, 32'd0);
        cycle();
        bus0.out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("en_off_drained", {31'b0, bus0.out_valid}, 32'd0);
        cycle();
        bus0.in_valid = 1'b0;
        en0 = 1'b1;

        // Counter wrap on a 2-bit counter
        bus1.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(1'b1, 3'(i), alt_y[i]);
            cycle();
            check("wrap_count", {30'b0, cnt_dut1}, {30'b0, alt_cnt[i]});
        end

        // Active-low output polarity
        bus1.out_ready = 1'b0;
        push(1'b1, 3'd6, 8'hBF);
        @(negedge clk);
        check("low_y", {24'b0, bus1.out_y}, 32'hBF);
        cycle();
        bus1.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("low_idle_y",     {24'b0, bus1.out_y},     32'hFF);
        check("low_idle_valid", {31'b0, bus1.out_valid}, 32'd0);

        repeat (3) @(negedge clk);
        check("q0_drained", q0.size(), 32'd0);
        check("q1_drained", q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
